pmp_csr: RTL and testbench

Machine-mode PMP configuration register file. It holds pmpcfg0/pmpcfg2 and pmpaddr0..pmpaddr(REGION_COUNT-1), and executes CSR read/write/set/clear accesses from the CSR unit with the RISC-V WARL and lock rules. It drives the per-region `pmp_cfg_t` and 56-bit address vectors that the PMP checker consumes. All outputs are registered, so a committed write is visible to the checker on the cycle after it takes effect.

---
 rtl/pmp_csr.sv | 204 ++++++++++++++++++++
 tb/tb_pmp_csr.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/pmp_csr.sv
// Machine-mode PMP configuration CSR file: pmpcfg0/pmpcfg2 and pmpaddr0..N-1 with WARL and lock rules.
// Optional feature macro: PMP_NA4_EN (keep A=NA4 as written; otherwise NA4 is stored as OFF).
module pmp_csr #(
    parameter int REGION_COUNT = 16
) (
    input  logic                              i_clk,
    input  logic                              i_rst_n,
    input  logic                              i_csr_valid,
    output logic                              o_csr_ready,
    input  logic [11:0]                       i_csr_addr,
    input  logic [1:0]                        i_csr_op,
    input  logic [63:0]                       i_csr_wdata,
    output logic                              o_csr_rvalid,
    output logic [63:0]                       o_csr_rdata,
    output logic                              o_csr_illegal,
    output logic [REGION_COUNT-1:0][7:0]      o_pmp_cfg,
    output logic [REGION_COUNT-1:0][55:0]     o_pmp_addr,
    output logic                              o_pmp_changed
);

    localparam logic [1:0] OP_READ  = 2'b00;
    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] OP_SET   = 2'b10;
    localparam logic [1:0] OP_CLEAR = 2'b11;

    localparam logic [1:0] A_OFF = 2'b00;
    localparam logic [1:0] A_TOR = 2'b01;
    localparam logic [1:0] A_NA4 = 2'b10;

    localparam logic [4:0] REGION_W = 5'(REGION_COUNT);
    localparam logic       HAS_CFG2 = (REGION_COUNT == 16) ? 1'b1 : 1'b0;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RESP = 1'b1
    } state_t;

    state_t                          state_r;
    state_t                          state_next_s;
    logic                            accept_s;

    logic [REGION_COUNT-1:0][7:0]    cfg_r;
    logic [REGION_COUNT-1:0][55:0]   addr_r;
    logic [REGION_COUNT-1:0][7:0]    cfg_next_s;
    logic [REGION_COUNT-1:0][55:0]   addr_next_s;
    logic [REGION_COUNT:0]           tor_lock_s;

    logic                            sel_cfg0_s;
    logic                            sel_cfg2_s;
    logic                            sel_addr_s;
    logic                            legal_s;
    logic                            wr_s;
    logic [127:0]                    cfg_flat_s;
    logic [63:0]                     addr_word_s;
    logic [63:0]                     old_word_s;
    logic [63:0]                     new_word_s;
    logic                            changed_s;

    logic                            ready_r;
    logic                            rvalid_r;
    logic [63:0]                     rdata_r;
    logic                            illegal_r;
    logic                            changed_r;

    // A byte with W set but R clear is rejected whole; reserved bits always read back 0.
    function automatic logic [7:0] cfg_warl(input logic [7:0] old_byte, input logic [7:0] cand);
        logic [1:0] mode;
        logic [7:0] res;
`ifdef PMP_NA4_EN
        mode = cand[4:3];
`else
        if (cand[4:3] == A_NA4) begin
            mode = A_OFF;
        end else begin
            mode = cand[4:3];
        end
`endif
        if (!cand[0] && cand[1]) begin
            res = old_byte;
        end else begin
            res = {cand[7], 2'b00, mode, cand[2:0]};
        end
        return res;
    endfunction

    // Handshake FSM: next state and accept strobe.
    always_comb begin
        state_next_s = state_r;
        accept_s     = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (i_csr_valid) begin
                    state_next_s = ST_RESP;
                    accept_s     = 1'b1;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_RESP: state_next_s = ST_IDLE;
            default: state_next_s = ST_IDLE;
        endcase
    end

    // Handshake FSM: state register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Address decode and old-value read mux.
    always_comb begin
        sel_cfg0_s  = (i_csr_addr == 12'h3A0);
        sel_cfg2_s  = (i_csr_addr == 12'h3A2) && HAS_CFG2;
        sel_addr_s  = (i_csr_addr[11:4] == 8'h3B) && ({1'b0, i_csr_addr[3:0]} < REGION_W);
        legal_s     = sel_cfg0_s || sel_cfg2_s || sel_addr_s;
        cfg_flat_s  = 128'(cfg_r);
        addr_word_s = 64'h0;
        for (int i = 0; i < REGION_COUNT; i++) begin
            addr_word_s = addr_word_s |
                ((i_csr_addr[3:0] == 4'(i)) ? {10'b0, addr_r[i][55:2]} : 64'h0);
        end
        if (sel_cfg0_s) begin
            old_word_s = cfg_flat_s[63:0];
        end else if (sel_cfg2_s) begin
            old_word_s = cfg_flat_s[127:64];
        end else if (sel_addr_s) begin
            old_word_s = addr_word_s;
        end else begin
            old_word_s = 64'h0;
        end
    end

    // Operand combine for write/set/clear.
    always_comb begin
        case (i_csr_op)
            OP_WRITE: new_word_s = i_csr_wdata;
            OP_SET:   new_word_s = old_word_s | i_csr_wdata;
            OP_CLEAR: new_word_s = old_word_s & ~i_csr_wdata;
            default:  new_word_s = old_word_s;
        endcase
        wr_s = accept_s && (i_csr_op != OP_READ) && legal_s;
    end

    // Per-region "locked TOR top" flags; the extra top bit keeps the last pmpaddr unlocked by a neighbour.
    always_comb begin
        tor_lock_s = '0;
        for (int i = 0; i < REGION_COUNT; i++) begin
            tor_lock_s[i] = cfg_r[i][7] && (cfg_r[i][4:3] == A_TOR);
        end
    end

    // Next cfg/addr state with lock and WARL filtering, evaluated against pre-access state.
    always_comb begin
        cfg_next_s  = cfg_r;
        addr_next_s = addr_r;
        for (int i = 0; i < REGION_COUNT; i++) begin
            if (wr_s && ((i < 8) ? sel_cfg0_s : sel_cfg2_s) && !cfg_r[i][7]) begin
                cfg_next_s[i] = cfg_warl(cfg_r[i], new_word_s[(i % 8) * 8 +: 8]);
            end else begin
                cfg_next_s[i] = cfg_r[i];
            end
            if (wr_s && sel_addr_s && (i_csr_addr[3:0] == 4'(i)) &&
                !cfg_r[i][7] && !tor_lock_s[i + 1]) begin
                addr_next_s[i] = {new_word_s[53:0], 2'b00};
            end else begin
                addr_next_s[i] = addr_r[i];
            end
        end
        changed_s = (cfg_next_s != cfg_r) || (addr_next_s != addr_r);
    end

    // Architectural state and registered response outputs.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cfg_r     <= '0;
            addr_r    <= '0;
            ready_r   <= 1'b1;
            rvalid_r  <= 1'b0;
            rdata_r   <= 64'h0;
            illegal_r <= 1'b0;
            changed_r <= 1'b0;
        end else begin
            cfg_r     <= cfg_next_s;
            addr_r    <= addr_next_s;
            ready_r   <= (state_next_s == ST_IDLE);
            rvalid_r  <= accept_s;
            rdata_r   <= accept_s ? old_word_s : 64'h0;
            illegal_r <= accept_s && !legal_s;
            changed_r <= changed_s;
        end
    end

    assign o_csr_ready   = ready_r;
    assign o_csr_rvalid  = rvalid_r;
    assign o_csr_rdata   = rdata_r;
    assign o_csr_illegal = illegal_r;
    assign o_pmp_changed = changed_r;
    assign o_pmp_cfg     = cfg_r;
    assign o_pmp_addr    = addr_r;

endmodule

// File: tb/tb_pmp_csr.sv
// Directed bench for pmp_csr: scoreboard of expected responses plus a hand-maintained cfg/addr image.
module tb_pmp_csr;

    localparam logic [1:0] OP_R = 2'b00;
    localparam logic [1:0] OP_W = 2'b01;
    localparam logic [1:0] OP_S = 2'b10;
    localparam logic [1:0] OP_C = 2'b11;

    typedef struct {
        logic [63:0] rdata;
        logic        illegal;
        logic        changed;
    } exp_t;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b1;
    logic                 valid;
    logic                 ready;
    logic [11:0]          addr;
    logic [1:0]           op;
    logic [63:0]          wdata;
    logic                 rvalid;
    logic [63:0]          rdata;
    logic                 illegal;
    logic [15:0][7:0]     cfg;
    logic [15:0][55:0]    paddr;
    logic                 changed;

    logic                 valid8;
    logic                 ready8;
    logic [11:0]          addr8;
    logic [1:0]           op8;
    logic [63:0]          wdata8;
    logic                 rvalid8;
    logic [63:0]          rdata8;
    logic                 illegal8;
    logic [7:0][7:0]      cfg8;
    logic [7:0][55:0]     paddr8;
    logic                 changed8;

    logic [15:0][7:0]     exp_cfg;
    logic [15:0][55:0]    exp_addr;
    exp_t                 q[$];
    int                   n_checks = 0;
    int                   n_errors = 0;

    always #5 clk = ~clk;

    pmp_csr #(.REGION_COUNT(16)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_csr_valid(valid), .o_csr_ready(ready),
        .i_csr_addr(addr), .i_csr_op(op), .i_csr_wdata(wdata), .o_csr_rvalid(rvalid),
        .o_csr_rdata(rdata), .o_csr_illegal(illegal), .o_pmp_cfg(cfg), .o_pmp_addr(paddr),
        .o_pmp_changed(changed)
    );

    pmp_csr #(.REGION_COUNT(8)) dut8 (
        .i_clk(clk), .i_rst_n(rst_n), .i_csr_valid(valid8), .o_csr_ready(ready8),
        .i_csr_addr(addr8), .i_csr_op(op8), .i_csr_wdata(wdata8), .o_csr_rvalid(rvalid8),
        .o_csr_rdata(rdata8), .o_csr_illegal(illegal8), .o_pmp_cfg(cfg8), .o_pmp_addr(paddr8),
        .o_pmp_changed(changed8)
    );

    task automatic chk(input string tag, input logic [895:0] obs, input logic [895:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Response monitor: every rvalid pulse must match the oldest expected response.
    always @(negedge clk) begin
        exp_t e;
        if (rvalid) begin
            if (q.size() == 0) begin
                chk("rvalid_unexpected", 896'(rvalid), 896'(1'b0));
            end else begin
                e = q.pop_front();
                chk("rdata", 896'(rdata), 896'(e.rdata));
                chk("illegal", 896'(illegal), 896'(e.illegal));
                chk("changed", 896'(changed), 896'(e.changed));
                chk("ready_in_resp", 896'(ready), 896'(1'b0));
            end
        end else begin
            chk("changed_idle", 896'(changed), 896'(1'b0));
        end
    end

    task automatic check_state(input string tag);
        chk({tag, "_cfg"}, 896'(cfg), 896'(exp_cfg));
        chk({tag, "_addr"}, 896'(paddr), 896'(exp_addr));
    endtask

    task automatic access(input logic [11:0] a, input logic [1:0] o, input logic [63:0] d,
                          input logic [63:0] x_rdata, input logic x_ill, input logic x_chg);
        exp_t e;
        int   n;
        n = 0;
        @(negedge clk);
        while (!ready && n < 8) begin
            @(negedge clk);
            n++;
        end
        chk("ready_wait", 896'(ready), 896'(1'b1));
        valid = 1'b1;
        addr  = a;
        op    = o;
        wdata = d;
        e.rdata = x_rdata;
        e.illegal = x_ill;
        e.changed = x_chg;
        q.push_back(e);
        @(posedge clk);
        #1;
        valid = 1'b0;
        n = 0;
        while (q.size() != 0 && n < 8) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("resp_timeout", 896'(q.size()), 896'(0));
        q.delete();
        check_state("state");
    endtask

    task automatic access8(input logic [11:0] a, input logic [1:0] o, input logic [63:0] d,
                           input logic [63:0] x_rdata, input logic x_ill, input logic x_chg);
        @(negedge clk);
        valid8 = 1'b1;
        addr8  = a;
        op8    = o;
        wdata8 = d;
        @(posedge clk);
        #1;
        valid8 = 1'b0;
        chk("r8_rvalid", 896'(rvalid8), 896'(1'b1));
        chk("r8_rdata", 896'(rdata8), 896'(x_rdata));
        chk("r8_illegal", 896'(illegal8), 896'(x_ill));
        chk("r8_changed", 896'(changed8), 896'(x_chg));
        @(posedge clk);
        #1;
    endtask

    initial begin
        valid = 1'b0; addr = 12'h0; op = OP_R; wdata = 64'h0;
        valid8 = 1'b0; addr8 = 12'h0; op8 = OP_R; wdata8 = 64'h0;
        exp_cfg = '0;
        exp_addr = '0;
        #2 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_ready", 896'(ready), 896'(1'b1));
        chk("rst_rvalid", 896'(rvalid), 896'(1'b0));
        chk("rst_rdata", 896'(rdata), 896'(64'h0));
        chk("rst_illegal", 896'(illegal), 896'(1'b0));
        check_state("rst");
        rst_n = 1'b1;

        access(12'h3A0, OP_R, 64'h0, 64'h0, 1'b0, 1'b0);
        exp_addr[0] = 56'h1000;
        access(12'h3B0, OP_W, 64'h400, 64'h0, 1'b0, 1'b1);
        access(12'h3B0, OP_R, 64'h0, 64'h400, 1'b0, 1'b0);
        exp_addr[0] = 56'hFF_FFFF_FFFF_FFFC;
        access(12'h3B0, OP_W, 64'hFFFF_FFFF_FFFF_FFFF, 64'h400, 1'b0, 1'b1);
        access(12'h3B0, OP_R, 64'h0, 64'h003F_FFFF_FFFF_FFFF, 1'b0, 1'b0);

        // Lock cfg[1] as TOR: freezes cfg[1], pmpaddr1 and pmpaddr0.
        exp_cfg[1] = 8'h8F;
        access(12'h3A0, OP_W, 64'h8F00, 64'h0, 1'b0, 1'b1);
        access(12'h3B0, OP_W, 64'h123, 64'h003F_FFFF_FFFF_FFFF, 1'b0, 1'b0);
        access(12'h3B1, OP_W, 64'h5, 64'h0, 1'b0, 1'b0);
        access(12'h3A0, OP_W, 64'h0, 64'h8F00, 1'b0, 1'b0);

        access(12'h3A0, OP_W, 64'h2, 64'h8F00, 1'b0, 1'b0);
        exp_cfg[0] = 8'h01;
        access(12'h3A0, OP_S, 64'h1, 64'h8F00, 1'b0, 1'b1);
        exp_cfg[0] = 8'h03;
        access(12'h3A0, OP_S, 64'h2, 64'h8F01, 1'b0, 1'b1);
        access(12'h3A0, OP_C, 64'h1, 64'h8F03, 1'b0, 1'b0);
        exp_cfg[2] = 8'h07;
        access(12'h3A0, OP_W, 64'h67_8F03, 64'h8F03, 1'b0, 1'b1);
        access(12'h3A0, OP_R, 64'h0, 64'h07_8F03, 1'b0, 1'b0);

        access(12'h3A1, OP_W, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1, 1'b0);
        access(12'h3C0, OP_W, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1, 1'b0);
        exp_addr[15] = 56'h2AF0;
        access(12'h3BF, OP_W, 64'hABC, 64'h0, 1'b0, 1'b1);

`ifdef PMP_NA4_EN
        exp_cfg[0] = 8'h11;
`else
        exp_cfg[0] = 8'h01;
`endif
        access(12'h3A0, OP_W, 64'h07_8F11, 64'h07_8F03, 1'b0, 1'b1);
        exp_cfg[9] = 8'h0D;
        access(12'h3A2, OP_W, 64'h0D00, 64'h0, 1'b0, 1'b1);
        access(12'h3A2, OP_R, 64'h0, 64'h0D00, 1'b0, 1'b0);
        exp_cfg[9] = 8'h00;
        access(12'h3A2, OP_C, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0D00, 1'b0, 1'b1);

        access8(12'h3A2, OP_R, 64'h0, 64'h0, 1'b1, 1'b0);
        access8(12'h3B7, OP_W, 64'h55, 64'h0, 1'b0, 1'b1);
        chk("r8_addr7", 896'(paddr8[7]), 896'(56'h154));
        access8(12'h3B8, OP_W, 64'h1, 64'h0, 1'b1, 1'b0);
        access8(12'h3A0, OP_R, 64'h0, 64'h0, 1'b0, 1'b0);

        // Reset during the response cycle aborts it.
        @(negedge clk);
        valid = 1'b1; addr = 12'h3B2; op = OP_W; wdata = 64'h7;
        @(posedge clk);
        #1;
        valid = 1'b0;
        chk("abort_rvalid_before", 896'(rvalid), 896'(1'b1));
        rst_n = 1'b0;
        #1;
        exp_cfg = '0;
        exp_addr = '0;
        chk("abort_rvalid", 896'(rvalid), 896'(1'b0));
        chk("abort_ready", 896'(ready), 896'(1'b1));
        check_state("abort");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("abort_no_late_rvalid", 896'(rvalid), 896'(1'b0));
        chk("queue_empty", 896'(q.size()), 896'(0));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
